stream_fifo_bridge: RTL and testbench

Parametrised elastic buffer between two `stream_bus` interface instances. Data width is not a module parameter: it is read by hierarchical cross-reference from the interface parameters (`in_bus.DATA_W`, `out_bus.DATA_W`). Depth, almost-full threshold and output mode are module parameters. It sits between a producer and a consumer whose interface instances were parametrised independently, typically from an enclosing interface's parameters. It is the valid/ready successor to the plain `logic a`-only bus.

---
 rtl/stream_fifo_bridge_pkg.sv | 14 +
 rtl/stream_fifo_bridge_if.sv | 11 +
 rtl/stream_fifo_bridge_mem.sv | 22 ++
 rtl/stream_fifo_bridge.sv | 122 ++++++++++++
 tb/tb_stream_fifo_bridge.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_fifo_bridge_pkg.sv
// Shared types and helpers for the stream FIFO bridge.
// Pointer wrap is explicit so non-power-of-two depths index correctly.
package stream_pkg;
  localparam int DEFAULT_DATA_W = 8;
  localparam int MAX_DEPTH = 256;
  localparam int PTR_W = $clog2(MAX_DEPTH);

  typedef enum logic {EMPTY_O, FULL_O} out_state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr, input int depth);
    if (int'(ptr) >= depth - 1) return '0;
    return ptr + 1'b1;
  endfunction
endpackage

// File: rtl/stream_fifo_bridge_if.sv
// Valid/ready stream bus; width travels with the interface instance.
interface stream_bus #(parameter int DATA_W = stream_pkg::DEFAULT_DATA_W);
  localparam int DATA_B = (DATA_W + 7) / 8;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport src (output valid, data, input ready);
  modport snk (input valid, data, output ready);
endinterface

// File: rtl/stream_fifo_bridge_mem.sv
// 1-write/1-read register array, asynchronous read, no reset on contents.
// Latency: write visible on the read port the cycle after the write edge.
module stream_fifo_mem #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdat,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdat
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];
endmodule

// File: rtl/stream_fifo_bridge.sv
// Elastic buffer between two stream_bus instances, zero-extending to the output width.
// Latency 1 cycle (FWFT) or 2 (registered output); ready depends only on registered count.
module stream_fifo_bridge
  import stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AFULL_LVL = DEPTH - 1,
  parameter bit OUT_REG = 1'b0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_bus.snk           in_bus,
  stream_bus.src           out_bus,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             afull,
  output logic [CNT_W-1:0] peak
);
  localparam int IN_W = in_bus.DATA_W;
  localparam int OUT_W = out_bus.DATA_W;
  localparam int AW = $clog2(DEPTH);

  if (OUT_W < IN_W) begin : g_err_width
    $error("stream_fifo_bridge: output width narrower than input width");
  end
  if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_err_depth
    $error("stream_fifo_bridge: DEPTH out of range");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_err_afull
    $error("stream_fifo_bridge: AFULL_LVL out of range");
  end

  logic             push, pop_out, pop_arr, out_vld;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [IN_W-1:0]  rd_dat;
  logic [OUT_W-1:0] out_dat;
  logic [CNT_W-1:0] arr_cnt, arr_cnt_nxt, count_nxt;

  assign in_bus.ready  = rst_n && (count < CNT_W'(DEPTH));
  assign push          = in_bus.valid && in_bus.ready;
  assign pop_out       = out_vld && out_bus.ready;
  assign out_bus.valid = out_vld;
  assign out_bus.data  = out_dat;

  // count covers the output register too; arr_cnt tracks only the array
  assign count_nxt   = count + CNT_W'(push) - CNT_W'(pop_out);
  assign arr_cnt_nxt = arr_cnt + CNT_W'(push) - CNT_W'(pop_arr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      arr_cnt <= '0;
      count   <= '0;
      empty   <= 1'b1;
      afull   <= 1'b0;
      peak    <= '0;
    end else begin
      if (push)    wr_ptr <= AW'(ptr_inc(PTR_W'(wr_ptr), DEPTH));
      if (pop_arr) rd_ptr <= AW'(ptr_inc(PTR_W'(rd_ptr), DEPTH));
      arr_cnt <= arr_cnt_nxt;
      count   <= count_nxt;
      empty   <= (count_nxt == '0);
      afull   <= (count_nxt >= CNT_W'(AFULL_LVL));
      if (count_nxt > peak) peak <= count_nxt;
    end
  end

  stream_fifo_mem #(.W(IN_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdat  (in_bus.data),
    .raddr (rd_ptr),
    .rdat  (rd_dat)
  );

  if (OUT_REG) begin : g_reg
    out_state_e       state, state_nxt;
    logic             load;
    logic [OUT_W-1:0] hold_dat;

    always_ff @(posedge clk) begin
      if (!rst_n) state <= EMPTY_O;
      else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
      if (load) hold_dat <= OUT_W'(rd_dat);
    end

    always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
        EMPTY_O: begin
          if (arr_cnt != '0) begin
            load      = 1'b1;
            state_nxt = FULL_O;
          end
        end
        FULL_O: begin
          // a pop either reloads from the array on the same edge or empties the stage
          if (out_bus.ready) begin
            if (arr_cnt != '0) load = 1'b1;
            else               state_nxt = EMPTY_O;
          end
        end
        default: state_nxt = EMPTY_O;
      endcase
    end

    assign pop_arr = load;
    assign out_vld = rst_n && (state == FULL_O);
    assign out_dat = hold_dat;
  end else begin : g_fwft
    assign pop_arr = pop_out;
    assign out_vld = rst_n && (arr_cnt != '0);
    assign out_dat = OUT_W'(rd_dat);
  end
endmodule

// File: tb/tb_stream_fifo_bridge.sv
// Scoreboard bench for stream_fifo_bridge: FWFT depth 4, widening depth 3, registered output.
module tb_stream_fifo_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  stream_bus #(.DATA_W(8))  a_in ();
  stream_bus #(.DATA_W(8))  a_out ();
  stream_bus #(.DATA_W(8))  b_in ();
  stream_bus #(.DATA_W(16)) b_out ();
  stream_bus #(.DATA_W(8))  c_in ();
  stream_bus #(.DATA_W(16)) c_out ();

  logic [2:0] a_cnt, a_pk;
  logic [1:0] b_cnt, b_pk;
  logic [2:0] c_cnt, c_pk;
  logic a_emp, a_af, b_emp, b_af, c_emp, c_af;

  stream_fifo_bridge #(.DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_bus(a_in), .out_bus(a_out),
    .count(a_cnt), .empty(a_emp), .afull(a_af), .peak(a_pk));
  stream_fifo_bridge #(.DEPTH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_bus(b_in), .out_bus(b_out),
    .count(b_cnt), .empty(b_emp), .afull(b_af), .peak(b_pk));
  stream_fifo_bridge #(.DEPTH(4), .OUT_REG(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_bus(c_in), .out_bus(c_out),
    .count(c_cnt), .empty(c_emp), .afull(c_af), .peak(c_pk));

  logic [15:0] qa[$], qb[$], qc[$];
  int b_got = 0;
  int c_n = 0;
  int c_first = -1;
  int c_last = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got word 0x%0h, expected no output", nm, act);
  endtask

  // Monitors: pop the expected word whenever a handshake is about to complete
  always @(negedge clk) begin
    if (rst_n && a_out.valid && a_out.ready) begin
      if (qa.size() == 0) unexpected("a_out", 32'(a_out.data));
      else chk("a_out data", 32'(a_out.data), 32'(qa.pop_front()));
    end
    if (rst_n && b_out.valid && b_out.ready) begin
      b_got++;
      if (qb.size() == 0) unexpected("b_out", 32'(b_out.data));
      else chk("b_out data", 32'(b_out.data), 32'(qb.pop_front()));
    end
    if (rst_n && c_out.valid && c_out.ready) begin
      c_n++;
      if (c_first < 0) c_first = cyc;
      c_last = cyc;
      if (qc.size() == 0) unexpected("c_out", 32'(c_out.data));
      else chk("c_out data", 32'(c_out.data), 32'(qc.pop_front()));
    end
  end

  function automatic logic in_rdy(input int id);
    case (id)
      0:       return a_in.ready;
      1:       return b_in.ready;
      default: return c_in.ready;
    endcase
  endfunction

  // Present a word, wait for acceptance, queue its expected (zero-extended) value.
  // Returns #1 after the accepting edge with valid still high.
  task automatic send(input int id, input logic [7:0] d, input logic [15:0] exp);
    int n = 0;
    case (id)
      0:       begin a_in.valid = 1'b1; a_in.data = d; end
      1:       begin b_in.valid = 1'b1; b_in.data = d; end
      default: begin c_in.valid = 1'b1; c_in.data = d; end
    endcase
    @(negedge clk);
    while (!in_rdy(id)) begin
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send%0d timeout: in ready 0, expected 1", id);
        return;
      end
      @(negedge clk);
    end
    case (id)
      0:       qa.push_back(exp);
      1:       qb.push_back(exp);
      default: qc.push_back(exp);
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic drain_wait(input int id);
    int n = 0;
    while (((id == 0) ? qa.size() : (id == 1) ? qb.size() : qc.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain timeout", 32'(n >= 200), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_in.valid = 0; a_in.data = '0; a_out.ready = 0;
    b_in.valid = 0; b_in.data = '0; b_out.ready = 0;
    c_in.valid = 0; c_in.data = '0; c_out.ready = 0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready during reset", 32'(a_in.ready), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rst in ready", 32'(a_in.ready), 32'd1);
    chk("rst out valid", 32'(a_out.valid), 32'd0);
    chk("rst count", 32'(a_cnt), 32'd0);
    chk("rst empty", 32'(a_emp), 32'd1);
    chk("rst afull", 32'(a_af), 32'd0);
    chk("rst peak", 32'(a_pk), 32'd0);

    // Fill depth-4 FIFO with consumer stalled
    @(posedge clk); #1;
    send(0, 8'h11, 16'h0011); chk("fill1 count", 32'(a_cnt), 32'd1);
    send(0, 8'h22, 16'h0022); chk("fill2 afull", 32'(a_af), 32'd0);
    send(0, 8'h33, 16'h0033); chk("fill3 afull", 32'(a_af), 32'd1);
    send(0, 8'h44, 16'h0044);
    chk("full count", 32'(a_cnt), 32'd4);
    chk("full peak", 32'(a_pk), 32'd4);
    a_in.data = 8'h55;
    @(negedge clk); chk("full in ready", 32'(a_in.ready), 32'd0);
    @(negedge clk); chk("full 0x55 held", 32'(a_cnt), 32'd4);

    // Pop while full: 0x55 must not slip in on the same edge
    @(posedge clk); #1; a_out.ready = 1'b1;
    @(negedge clk); chk("pop-full in ready", 32'(a_in.ready), 32'd0);
    @(posedge clk); #1; a_out.ready = 1'b0;
    @(negedge clk);
    chk("after pop count", 32'(a_cnt), 32'd3);
    chk("after pop in ready", 32'(a_in.ready), 32'd1);
    qa.push_back(16'h0055);
    @(posedge clk); #1; a_in.valid = 1'b0;
    chk("0x55 accepted count", 32'(a_cnt), 32'd4);
    a_out.ready = 1'b1;
    drain_wait(0);
    @(posedge clk); #1; a_out.ready = 1'b0;
    chk("drained empty", 32'(a_emp), 32'd1);
    chk("drained count", 32'(a_cnt), 32'd0);
    chk("drained peak", 32'(a_pk), 32'd4);

    // Depth 3, 8 -> 16 bit, stalled start then random ready
    fork
      begin
        for (int i = 0; i < 20; i++) send(1, 8'(i), 16'(i));
        b_in.valid = 1'b0;
      end
      begin
        for (int k = 0; k < 2000 && b_got < 20; k++) begin
          @(posedge clk); #1;
          b_out.ready = (k < 6) ? 1'b0 : 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1; b_out.ready = 1'b0;
    chk("b words out", 32'(b_got), 32'd20);
    chk("b peak", 32'(b_pk), 32'd3);
    chk("b empty", 32'(b_emp), 32'd1);

    // Registered output: two-cycle latency and hold under backpressure
    c_in.valid = 1'b1; c_in.data = 8'hA5;
    @(negedge clk); chk("c in ready", 32'(c_in.ready), 32'd1);
    qc.push_back(16'h00A5);
    @(posedge clk); #1; c_in.valid = 1'b0;
    @(negedge clk);
    chk("c valid N+1", 32'(c_out.valid), 32'd0);
    chk("c count N+1", 32'(c_cnt), 32'd1);
    @(negedge clk);
    chk("c valid N+2", 32'(c_out.valid), 32'd1);
    chk("c data N+2", 32'(c_out.data), 32'h00A5);
    chk("c count N+2", 32'(c_cnt), 32'd1);
    @(negedge clk);
    chk("c hold valid", 32'(c_out.valid), 32'd1);
    chk("c hold data", 32'(c_out.data), 32'h00A5);
    @(posedge clk); #1; c_out.ready = 1'b1;
    drain_wait(2);
    @(posedge clk); #1;
    c_n = 0; c_first = -1; c_last = -1;
    for (int i = 1; i <= 8; i++) send(2, 8'(i), 16'(i));
    c_in.valid = 1'b0;
    drain_wait(2);
    @(posedge clk); #1; c_out.ready = 1'b0;
    chk("c burst words", 32'(c_n), 32'd8);
    chk("c burst span", 32'(c_last - c_first), 32'd7);
    chk("c empty", 32'(c_emp), 32'd1);

    // Mid-operation reset discards held words
    send(0, 8'h61, 16'h0061);
    send(0, 8'h62, 16'h0062);
    send(0, 8'h63, 16'h0063);
    a_in.valid = 1'b0;
    chk("pre-reset count", 32'(a_cnt), 32'd3);
    rst_n = 1'b0;
    qa.delete();
    @(negedge clk); chk("reset in ready", 32'(a_in.ready), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    chk("post-reset count", 32'(a_cnt), 32'd0);
    chk("post-reset peak", 32'(a_pk), 32'd0);
    chk("post-reset valid", 32'(a_out.valid), 32'd0);
    chk("post-reset empty", 32'(a_emp), 32'd1);
    a_out.ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    send(0, 8'h77, 16'h0077);
    a_in.valid = 1'b0;
    drain_wait(0);
    @(posedge clk); #1; a_out.ready = 1'b0;
    chk("final a empty", 32'(a_emp), 32'd1);
    chk("final queues", 32'(qa.size() + qb.size() + qc.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
